ha_iter_adder_seq: RTL and testbench

- Iterative two-operand adder built from a single row of WIDTH half-adder (2:1 compressor) cells, reused every cycle.
- Each cycle performs one step: sum = sum XOR carry, carry = (sum AND carry) << 1. The sequence repeats until the carry vector is zero.
- Sits in src/comm as an area-minimal adder and as a carry-resolution engine for carry-save results.
- Uses a valid/ready handshake on input and output. Latency is data-dependent.

---
 rtl/alu_comm_pkg.sv | 22 ++
 rtl/ha_row.sv | 23 ++
 rtl/ha_iter_adder_seq.sv | 119 +++++++++++
 tb/tb_ha_iter_adder_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_comm_pkg.sv
// ============================================================================
// alu_comm_pkg : shared types and helpers for the comm arithmetic blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_comm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } ha_iter_state_e;

  // Iteration counter must hold WIDTH+1, the worst-case step count.
  function automatic int iter_width(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ha_row.sv
// ============================================================================
// ha_row : one row of WIDTH independent half-adder (2:1 compressor) cells
// Rev 1.0
// ============================================================================
`default_nettype none

module ha_row #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum[i]  = a[i] ^ b[i];
    assign cout[i] = a[i] & b[i];
  end

endmodule

`default_nettype wire

// File: rtl/ha_iter_adder_seq.sv
// ============================================================================
// ha_iter_adder_seq : iterative adder reusing one half-adder row per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module ha_iter_adder_seq
  import alu_comm_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ITER_W = iter_width(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              in_cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic              out_cout,
  output logic [ITER_W-1:0] out_iter
);

  ha_iter_state_e    state_q, state_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [WIDTH-1:0]  carry_q, carry_d;
  logic              inj_q, inj_d;
  logic              cout_q, cout_d;
  logic [ITER_W-1:0] iter_q, iter_d;

  logic [WIDTH-1:0]  row_sum;
  logic [WIDTH-1:0]  row_gen;
  logic [WIDTH-1:0]  carry_nxt;
  logic              accept;

  ha_row #(.WIDTH(WIDTH)) u_row (
    .a    (sum_q),
    .b    (carry_q),
    .sum  (row_sum),
    .cout (row_gen)
  );

  // Carry-in enters at bit 0 on the first step, filling the slot the shift opens.
  assign carry_nxt = {row_gen[WIDTH-2:0], inj_q};
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ITER;
      ITER:    if (carry_nxt == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    inj_d   = inj_q;
    cout_d  = cout_q;
    iter_d  = iter_q;
    if (state_q == IDLE && accept) begin
      sum_d   = in_a;
      carry_d = in_b;
      inj_d   = in_cin;
      cout_d  = 1'b0;
      iter_d  = '0;
    end else if (state_q == ITER) begin
      sum_d   = row_sum;
      carry_d = carry_nxt;
      inj_d   = 1'b0;
      cout_d  = cout_q | row_gen[WIDTH-1];
      iter_d  = iter_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      inj_q   <= 1'b0;
      cout_q  <= 1'b0;
      iter_q  <= '0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      inj_q   <= inj_d;
      cout_q  <= cout_d;
      iter_q  <= iter_d;
    end
  end

  // in_ready is masked by rst so nothing looks acceptable while reset is held.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    out_sum   = out_valid ? sum_q  : '0;
    out_cout  = out_valid ? cout_q : 1'b0;
    out_iter  = out_valid ? iter_q : '0;
  end

  a_iter_bound: assert property (@(posedge clk) disable iff (rst)
    iter_q <= ITER_W'(WIDTH + 1));

endmodule

`default_nettype wire

// File: tb/tb_ha_iter_adder_seq.sv
// ============================================================================
// tb_ha_iter_adder_seq : directed and random checks for ha_iter_adder_seq
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ha_iter_adder_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
  logic [7:0]  in_a, in_b, out_sum;
  logic [3:0]  out_iter;

  logic        w_valid, w_ready, w_cin, w_ovalid, w_oready, w_cout;
  logic [31:0] w_a, w_b, w_sum;
  logic [5:0]  w_iter;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ha_iter_adder_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_iter(out_iter)
  );

  ha_iter_adder_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(w_ready),
    .in_a(w_a), .in_b(w_b), .in_cin(w_cin), .out_valid(w_ovalid),
    .out_ready(w_oready), .out_sum(w_sum), .out_cout(w_cout), .out_iter(w_iter)
  );

  // Present one operand set, wait for the accept edge, then scramble inputs.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = c;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_cin = ~c;
  endtask

  // Counts clock edges after the accept edge until out_valid is seen.
  task automatic wait_out8(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic pop8();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if ({out_cout, out_sum, out_iter} !== 13'd0) begin bad++;
      $display("FAIL rst_outputs got=%b/%h/%0d exp=0/00/0", out_cout, out_sum, out_iter); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
    total++; if (w_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready32 got=%b exp=1", w_ready); end
  endtask

  task automatic test_directed_vectors();
    logic [7:0] va [6] = '{8'h05, 8'hFF, 8'hFF, 8'h12, 8'h80, 8'hAA};
    logic [7:0] vb [6] = '{8'h03, 8'h01, 8'h00, 8'h00, 8'h80, 8'h55};
    logic       vc [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
    logic [7:0] es [6] = '{8'h08, 8'h00, 8'h00, 8'h12, 8'h00, 8'h00};
    logic       ec [6] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
    int         ek [6] = '{4,     8,     9,     1,     1,     9};
    int lat;
    for (int i = 0; i < 6; i++) begin
      issue8(va[i], vb[i], vc[i]);
      wait_out8(lat);
      total++; if (lat != ek[i]) begin bad++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, ek[i]); end
      total++; if (out_sum !== es[i]) begin bad++; $display("FAIL vec%0d_sum got=%h exp=%h", i, out_sum, es[i]); end
      total++; if (out_cout !== ec[i]) begin bad++; $display("FAIL vec%0d_cout got=%b exp=%b", i, out_cout, ec[i]); end
      total++; if (out_iter !== 4'(ek[i])) begin bad++; $display("FAIL vec%0d_iter got=%0d exp=%0d", i, out_iter, ek[i]); end
      pop8();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
        $display("FAIL vec%0d_pop got valid=%b ready=%b exp valid=0 ready=1", i, out_valid, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue8(8'h05, 8'h03, 1'b0);
    wait_out8(lat);
    in_valid = 1'b1; in_a = 8'h10; in_b = 8'h20; in_cin = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_sum !== 8'h08 || out_cout !== 1'b0 || out_iter !== 4'd4) begin bad++;
        $display("FAIL bp_hold%0d got v=%b s=%h c=%b k=%0d exp v=1 s=08 c=0 k=4", c, out_valid, out_sum, out_cout, out_iter); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d got=%b exp=0", c, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
      $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out8(lat);
    total++; if (lat != 1) begin bad++; $display("FAIL bp_next_latency got=%0d exp=1", lat); end
    total++; if (out_sum !== 8'h30 || out_iter !== 4'd1) begin bad++;
      $display("FAIL bp_next_result got s=%h k=%0d exp s=30 k=1", out_sum, out_iter); end
    pop8();
  endtask

  task automatic test_reset_mid_iter();
    int lat;
    issue8(8'hFF, 8'h01, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++;
      $display("FAIL mid_rst_flags got valid=%b ready=%b exp 0/0", out_valid, in_ready); end
    total++; if ({out_cout, out_sum, out_iter} !== 13'd0) begin bad++;
      $display("FAIL mid_rst_outputs got=%b/%h/%0d exp=0/00/0", out_cout, out_sum, out_iter); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_release got=%b exp=1", in_ready); end
    issue8(8'h21, 8'h13, 1'b0);
    wait_out8(lat);
    total++; if (out_sum !== 8'h34 || out_cout !== 1'b0 || out_iter !== 4'd3 || lat != 3) begin bad++;
      $display("FAIL mid_rst_next got s=%h c=%b k=%0d lat=%0d exp s=34 c=0 k=3 lat=3", out_sum, out_cout, out_iter, lat); end
    pop8();
  endtask

  task automatic test_random8();
    logic [7:0] a, b;
    logic       c;
    logic [8:0] exp;
    int lat;
    for (int n = 0; n < 300; n++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + 9'(c);
      issue8(a, b, c);
      wait_out8(lat);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); @(negedge clk); end
      total++; if ({out_cout, out_sum} !== exp) begin bad++;
        $display("FAIL rnd8_sum a=%h b=%h c=%b got=%h exp=%h", a, b, c, {out_cout, out_sum}, exp); end
      total++; if (out_iter < 1 || out_iter > 9 || lat != int'(out_iter)) begin bad++;
        $display("FAIL rnd8_iter a=%h b=%h c=%b got k=%0d lat=%0d exp 1..9 and equal", a, b, c, out_iter, lat); end
      pop8();
    end
  endtask

  task automatic test_random32();
    logic [31:0] a, b;
    logic        c;
    logic [32:0] exp;
    int lat, g;
    for (int n = 0; n < 200; n++) begin
      a = $urandom; b = $urandom; c = 1'($urandom);
      if (n == 0) begin a = 32'hFFFF_FFFF; b = 32'h0; c = 1'b1; end
      exp = {1'b0, a} + {1'b0, b} + 33'(c);
      g = 0;
      @(negedge clk);
      while (!w_ready && g < 200) begin @(negedge clk); g++; end
      w_valid = 1'b1; w_a = a; w_b = b; w_cin = c;
      @(posedge clk);
      @(negedge clk);
      w_valid = 1'b0; w_a = ~a; w_b = ~b;
      lat = 0;
      while (!w_ovalid && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); @(negedge clk); end
      total++; if ({w_cout, w_sum} !== exp) begin bad++;
        $display("FAIL rnd32_sum a=%h b=%h c=%b got=%h exp=%h", a, b, c, {w_cout, w_sum}, exp); end
      total++; if (w_iter < 1 || w_iter > 33 || lat != int'(w_iter) || (n == 0 && w_iter != 33)) begin bad++;
        $display("FAIL rnd32_iter a=%h b=%h c=%b got k=%0d lat=%0d exp 1..33 and equal", a, b, c, w_iter, lat); end
      w_oready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      w_oready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    w_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_oready = 1'b0;
    test_reset();
    test_directed_vectors();
    test_backpressure();
    test_reset_mid_iter();
    test_random8();
    test_random32();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
